// File: rtl/cs_win_pkg.sv
// Shared widths, defaults and the width helper for the sliding-window
// approximate-average filter.
package cs_win_pkg;

    localparam int unsigned DEF_DW    = 8;
    localparam int unsigned DEF_DEPTH = 9;
    localparam int unsigned DEF_SHIFT = 3;
    localparam int unsigned DEF_OW    = 10;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) r = i + 1;
        end
        return r;
    endfunction

    // Running sum of DEPTH samples of DW bits.
    function automatic int unsigned sum_width(input int unsigned dw, input int unsigned depth);
        return dw + clog2(depth);
    endfunction

    // S + DEPTH*near never exceeds 2*S because near never exceeds the mean.
    function automatic int unsigned total_width(input int unsigned dw, input int unsigned depth);
        return sum_width(dw, depth) + 1;
    endfunction

endpackage

// File: rtl/cs_window_filter_if.sv
// Sample-in / result-out bus of the window filter.
interface cs_window_filter_if #(
    parameter int unsigned DW = cs_win_pkg::DEF_DW,
    parameter int unsigned OW = cs_win_pkg::DEF_OW
) ();
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [OW-1:0] out_data;

    modport master (output in_valid, output in_data, input out_valid, input out_data);
    modport slave  (input in_valid, input in_data, output out_valid, output out_data);
endinterface

// File: rtl/cs_win_near.sv
// Combinational finder of the largest window sample whose DEPTH multiple does
// not exceed the running sum; per-tap qualify, then a balanced max tree.
module cs_win_near
    import cs_win_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic [DEPTH*DW-1:0]                win,
    input  logic [sum_width(DW, DEPTH)-1:0]    sum,
    output logic [DW-1:0]                      near
);
    localparam int unsigned SW = sum_width(DW, DEPTH);
    localparam int unsigned LV = clog2(DEPTH);

    logic [DW-1:0] cand_c [DEPTH];

    // Taps above the mean are forced to zero so they lose every max compare.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) cand_c[i] = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (SW'(DEPTH) * SW'(win[i*DW +: DW]) <= sum) cand_c[i] = win[i*DW +: DW];
        end
    end

    for (genvar l = 0; l <= LV; l++) begin : g_lvl
        localparam int unsigned N = 1 << (LV - l);
        logic [DW-1:0] v [N];
        for (genvar j = 0; j < N; j++) begin : g_node
            if (l == 0) begin : g_leaf
                if (j < DEPTH) begin : g_tap
                    assign v[j] = cand_c[j];
                end else begin : g_pad
                    assign v[j] = '0;
                end
            end else begin : g_max
                assign v[j] = (g_lvl[l-1].v[2*j] > g_lvl[l-1].v[2*j+1]) ?
                              g_lvl[l-1].v[2*j] : g_lvl[l-1].v[2*j+1];
            end
        end
    end

    assign near = g_lvl[LV].v[0];

endmodule

// File: rtl/cs_window_filter.sv
// Sliding-window approximate-average filter: out = (S + DEPTH*near) >> SHIFT.
// Define CS_WIN_WARMUP_EN to suppress results until the window is full.
module cs_window_filter
    import cs_win_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned SHIFT = DEF_SHIFT,
    parameter int unsigned OW    = DEF_OW
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    cs_window_filter_if.slave bus
);
    localparam int unsigned SW = sum_width(DW, DEPTH);
    localparam int unsigned TW = total_width(DW, DEPTH);

    logic [DW-1:0]       win [DEPTH];
    logic [DEPTH*DW-1:0] win_flat_c;
    logic [SW-1:0]       sum;
    logic                v0;
    logic                v0_nxt_c;
    logic                accept_c;
    logic [DW-1:0]       near_c;
    logic [DW-1:0]       near1;
    logic [SW-1:0]       sum1;
    logic                v1;
    logic [TW-1:0]       total_c;
    logic                out_valid;
    logic [OW-1:0]       out_data;

    assign accept_c = bus.in_valid && !clr;

`ifdef CS_WIN_WARMUP_EN
    localparam int unsigned CW = clog2(DEPTH + 1);
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt_c;

    assign cnt_nxt_c = (cnt == CW'(DEPTH)) ? cnt : cnt + CW'(1);
    assign v0_nxt_c  = accept_c && (cnt_nxt_c == CW'(DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        cnt <= '0;
        else if (clr)      cnt <= '0;
        else if (accept_c) cnt <= cnt_nxt_c;
    end
`else
    assign v0_nxt_c = accept_c;
`endif

    // Stage 0: window shift and running sum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) win[i] <= '0;
            sum <= '0;
            v0  <= 1'b0;
        end else if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) win[i] <= '0;
            sum <= '0;
            v0  <= 1'b0;
        end else begin
            v0 <= v0_nxt_c;
            if (accept_c) begin
                win[0] <= bus.in_data;
                for (int unsigned i = 1; i < DEPTH; i++) win[i] <= win[i-1];
                sum <= sum - SW'(win[DEPTH-1]) + SW'(bus.in_data);
            end
        end
    end

    always_comb begin
        win_flat_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) win_flat_c[i*DW +: DW] = win[i];
    end

    cs_win_near #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_near (
        .win  (win_flat_c),
        .sum  (sum),
        .near (near_c)
    );

    assign total_c = TW'(sum1) + TW'(DEPTH) * TW'(near1);

    // Stage 1 registers near/S; stage 2 scales and presents the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            near1     <= '0;
            sum1      <= '0;
            v1        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            near1     <= near_c;
            sum1      <= sum;
            v1        <= clr ? 1'b0 : v0;
            out_valid <= v1;
            if (v1) out_data <= OW'(total_c >> SHIFT);
        end
    end

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;

endmodule

// File: doc/cs_window_filter.md
# cs_window_filter

Parametrised sliding-window approximate-average filter for the series-computation datapath. It keeps the last DEPTH accepted samples and a running sum S, and finds "near": the largest window sample not exceeding the window mean. It emits (S + DEPTH·near) >> SHIFT through a registered, valid-qualified pipeline. It generalises the fixed 9-tap, 8-bit series block with configurable width, depth and scaling, input qualification, synchronous clear and warm-up gating.

## Interface
- DW, 8, sample width (bits)
- DEPTH, 9, window length, legal 3..16
- SHIFT, 3, output right-shift
- OW, 10, output width; result truncated to OW LSBs
- clk  input  1  clock, all flops rising-edge
- reset  input  1  asynchronous, active-low reset
- clr  input  1  synchronous window/pipeline clear
- in_valid  input  1  in_data valid this cycle
- in_data  input  DW  unsigned sample
- out_valid  output  1  out_data valid this cycle
- out_data  output  OW  filtered result

## Operation
- Sum width SW = DW + clog2(DEPTH). Total T = S + DEPTH·near, width SW+1, unsigned. Compute near and T with no overflow.
- Accept (in_valid=1, clr=0) does the following:
  - Shift the window: oldest sample out, in_data in.
  - S ← S − oldest + in_data.
  - Sample count cnt increments, saturating at DEPTH.
- in_valid=0: window, S and cnt hold.
- near = max over window w[i] with DEPTH·w[i] ≤ S. Ties are irrelevant because the value is unique. If no entry qualifies, near = 0.
- out_data = T >> SHIFT, truncated to OW bits.
- clr=1 clears window, S, cnt and both pipeline valid bits. It takes priority over a simultaneous in_valid; that sample is dropped.
- No backpressure. Every accepted sample that passes the warm-up gate produces exactly one out_valid pulse.

## Timing
- Reset (reset=0, asynchronous) clears window, S, cnt, stage registers, out_valid and out_data, all to 0, immediately. Deassertion is sampled at the next rising edge.
- Stage 0 (edge k, accept): window and S updated.
- Stage 1 (edge k+1): near and S registered; v1 ← accept-qualified valid from edge k.
- Stage 2 (edge k+2): out_data ← T >> SHIFT; out_valid ← v1.
- Latency: out_valid is high at edge k+2 for the sample accepted at edge k. One result per cycle at full rate.
- Gaps in in_valid propagate as out_valid=0 in the corresponding slot. out_data holds its last value while out_valid=0.
- clr at edge k: out_valid=0 for edges k+1 and k+2 regardless of earlier accepts.
- Reset mid-stream behaves like clr but is asynchronous. The first sample after release is treated as sample 1.

## Configuration
- CS_WIN_WARMUP_EN defined: a sample's stage-0 valid is set only if cnt = DEPTH after its accept. The first DEPTH−1 samples after reset or clr produce no out_valid.
- CS_WIN_WARMUP_EN undefined: every accept produces out_valid. Missing window entries count as zeros.

## Structure
- Package cs_win_pkg holds:
  - width function clog2
  - derived localparam formulas for SW and the T width
  - default parameter values as constants
- Sub-module cs_win_near is a combinational max-under-mean finder.
  - Inputs: flattened window and S. Output: near.
  - Implemented as a per-tap compare followed by a balanced max tree.
  - The top level instantiates it between stage 0 and stage 1.

## Test plan
- Reset: hold reset=0 with random inputs -> out_valid=0, out_data=0. Assert reset mid-stream -> both 0 without waiting for a clock edge.
- Warm-up (macro on): accept 12,15,9,21,17,5,8,6,11 back-to-back.
  - out_valid stays 0 for the first 8 samples.
  - After the 9th: S=104, near=11, out_data=25, out_valid exactly 2 cycles after the 9th accept.
- Slide: then accept 20 -> S=112, near=11, out_data=26 two cycles later. Insert a 3-cycle in_valid gap -> 3 out_valid=0 slots, window unchanged.
- Saturation: nine samples of 255 -> S=2295, near=255, out_data=573, no overflow.
- Clear: assert clr together with in_valid mid-stream.
  - Sample is dropped and out_valid=0 for the next 2 cycles.
  - The next 8 accepts give no output; the 9th gives a valid result.
- Macro off: first sample 72 after reset -> S=72, near=0, out_data=9, out_valid at k+2.
